// File: rtl/sgm_disparity_selector_pkg.sv
// Shared helpers for the SGM disparity selector slice.
package sgm_disparity_selector_pkg;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sgm_disparity_selector_argmin.sv
// One level of the winner-takes-all argmin tree: PAIRS registered pairwise
// compares; the lower index wins on equal cost.
module argmin_pipe_stage
  #(parameter int unsigned WIDTH    = 10,
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned PAIRS    = 1)
  (input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        valid,
   input  logic [2*PAIRS*WIDTH-1:0]    cost,
   input  logic [2*PAIRS*IDX_BITS-1:0] idx,
   output logic                        win_valid,
   output logic [PAIRS*WIDTH-1:0]      win_cost,
   output logic [PAIRS*IDX_BITS-1:0]   win_idx);

  logic [PAIRS*WIDTH-1:0]    sel_cost;
  logic [PAIRS*IDX_BITS-1:0] sel_idx;

  // Pick the smaller cost of each adjacent pair; ties go to the lower index.
  always_comb begin
    sel_cost = '0;
    sel_idx  = '0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      if ((cost[(2*p+1)*WIDTH +: WIDTH] < cost[2*p*WIDTH +: WIDTH]) ||
          ((cost[(2*p+1)*WIDTH +: WIDTH] == cost[2*p*WIDTH +: WIDTH]) &&
           (idx[(2*p+1)*IDX_BITS +: IDX_BITS] < idx[2*p*IDX_BITS +: IDX_BITS]))) begin
        sel_cost[p*WIDTH +: WIDTH]       = cost[(2*p+1)*WIDTH +: WIDTH];
        sel_idx[p*IDX_BITS +: IDX_BITS]  = idx[(2*p+1)*IDX_BITS +: IDX_BITS];
      end else begin
        sel_cost[p*WIDTH +: WIDTH]       = cost[2*p*WIDTH +: WIDTH];
        sel_idx[p*IDX_BITS +: IDX_BITS]  = idx[2*p*IDX_BITS +: IDX_BITS];
      end
    end
  end

  // Valid bit is the only reset state in this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_valid <= 1'b0;
    else        win_valid <= valid;
  end

  // Data registers load only with a valid pixel so results hold across bubbles.
  always_ff @(posedge clk) begin
    if (valid) begin
      win_cost <= sel_cost;
      win_idx  <= sel_idx;
    end
  end

endmodule

// File: rtl/sgm_disparity_selector.sv
// SGM disparity selector: sums NUM_PATHS path-cost vectors per disparity and
// picks the lowest-cost disparity through a pipelined argmin tree.
// Input sampled at edge k appears on the outputs after edge k+1+DISP_BITS.
module sgm_disparity_selector
  import sgm_disparity_selector_pkg::*;
  #(parameter int unsigned DISPARITY_LEVELS = 64,
    parameter int unsigned ACC_COST_BITS    = 8,
    parameter int unsigned NUM_PATHS        = 4,
    localparam int unsigned DISP_BITS = clog2(DISPARITY_LEVELS),
    localparam int unsigned SUM_BITS  = ACC_COST_BITS + clog2(NUM_PATHS))
  (input  logic                                              in_clk,
   input  logic                                              in_rst_n,
   input  logic                                              in_de,
   input  logic                                              in_line_start,
   input  logic [NUM_PATHS*DISPARITY_LEVELS*ACC_COST_BITS-1:0] in_L_arr,
   output logic                                              out_valid,
   output logic [DISP_BITS-1:0]                              out_disp,
   output logic [SUM_BITS-1:0]                               out_min_cost,
   output logic                                              out_line_start,
   output logic                                              out_border);

  localparam int unsigned D      = DISPARITY_LEVELS;
  localparam int unsigned LEAVES = 1 << DISP_BITS;
  localparam logic [DISP_BITS-1:0] MAX_DISP = DISP_BITS'(D - 1);

  logic [DISP_BITS-1:0] col;
  logic [DISP_BITS-1:0] cur_col;
  logic [SUM_BITS-1:0]  sum_comb [D];
  logic [SUM_BITS-1:0]  s0_sum   [D];
  logic                 s0_de, s0_ls, s0_border;

  logic [LEAVES*SUM_BITS-1:0]  leaf_cost;
  logic [LEAVES*DISP_BITS-1:0] leaf_idx;

  logic                 ls_pipe     [DISP_BITS];
  logic                 border_pipe [DISP_BITS];
  logic                 tree_valid;
  logic [SUM_BITS-1:0]  tree_cost;
  logic [DISP_BITS-1:0] tree_idx;

  assign cur_col = in_line_start ? '0 : col;

  // Per-disparity aggregation across paths, zero-extended to SUM_BITS.
  always_comb begin
    for (int unsigned d = 0; d < D; d++) begin
      sum_comb[d] = '0;
      for (int unsigned p = 0; p < NUM_PATHS; p++)
        sum_comb[d] = sum_comb[d] +
                      SUM_BITS'(in_L_arr[ACC_COST_BITS*(p*D+d) +: ACC_COST_BITS]);
    end
  end

  // Column counter: restarts on line start, saturates at MAX_DISP.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      col <= '0;
    end else if (in_de) begin
      if (in_line_start)        col <= DISP_BITS'(1);
      else if (col != MAX_DISP) col <= col + DISP_BITS'(1);
    end
  end

  // Stage 0 sideband, qualified by in_de so bubbles carry no flags.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s0_de     <= 1'b0;
      s0_ls     <= 1'b0;
      s0_border <= 1'b0;
    end else begin
      s0_de     <= in_de;
      s0_ls     <= in_de & in_line_start;
      s0_border <= in_de & (cur_col < MAX_DISP);
    end
  end

  // Stage 0 data: aggregated costs, loaded only for valid pixels.
  always_ff @(posedge in_clk) begin
    if (in_de) s0_sum <= sum_comb;
  end

  // Tree leaves; padding above MAX_DISP carries all-ones cost and index MAX_DISP.
  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < D) begin : g_real
      assign leaf_cost[j*SUM_BITS +: SUM_BITS]   = s0_sum[j];
      assign leaf_idx[j*DISP_BITS +: DISP_BITS]  = DISP_BITS'(j);
    end else begin : g_pad
      assign leaf_cost[j*SUM_BITS +: SUM_BITS]   = '1;
      assign leaf_idx[j*DISP_BITS +: DISP_BITS]  = MAX_DISP;
    end
  end

  for (genvar l = 0; l < DISP_BITS; l++) begin : g_stage
    localparam int unsigned PAIRS = LEAVES >> (l + 1);
    logic                         prev_valid;
    logic [2*PAIRS*SUM_BITS-1:0]  prev_cost;
    logic [2*PAIRS*DISP_BITS-1:0] prev_idx;
    logic                         stage_valid;
    logic [PAIRS*SUM_BITS-1:0]    stage_cost;
    logic [PAIRS*DISP_BITS-1:0]   stage_idx;

    if (l == 0) begin : g_first
      assign prev_valid = s0_de;
      assign prev_cost  = leaf_cost;
      assign prev_idx   = leaf_idx;
    end else begin : g_next
      assign prev_valid = g_stage[l-1].stage_valid;
      assign prev_cost  = g_stage[l-1].stage_cost;
      assign prev_idx   = g_stage[l-1].stage_idx;
    end

    argmin_pipe_stage #(.WIDTH(SUM_BITS), .IDX_BITS(DISP_BITS), .PAIRS(PAIRS)) u_stage (
      .clk       (in_clk),
      .rst_n     (in_rst_n),
      .valid     (prev_valid),
      .cost      (prev_cost),
      .idx       (prev_idx),
      .win_valid (stage_valid),
      .win_cost  (stage_cost),
      .win_idx   (stage_idx)
    );
  end

  assign tree_valid = g_stage[DISP_BITS-1].stage_valid;
  assign tree_cost  = g_stage[DISP_BITS-1].stage_cost;
  assign tree_idx   = g_stage[DISP_BITS-1].stage_idx;

  // Sideband flags follow the tree one stage per cycle.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int unsigned k = 0; k < DISP_BITS; k++) begin
        ls_pipe[k]     <= 1'b0;
        border_pipe[k] <= 1'b0;
      end
    end else begin
      ls_pipe[0]     <= s0_ls;
      border_pipe[0] <= s0_border;
      for (int unsigned k = 1; k < DISP_BITS; k++) begin
        ls_pipe[k]     <= ls_pipe[k-1];
        border_pipe[k] <= border_pipe[k-1];
      end
    end
  end

  // Output register; data holds its last result while out_valid is low.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_valid      <= 1'b0;
      out_line_start <= 1'b0;
      out_border     <= 1'b0;
      out_disp       <= '0;
      out_min_cost   <= '0;
    end else begin
      out_valid      <= tree_valid;
      out_line_start <= ls_pipe[DISP_BITS-1];
      out_border     <= border_pipe[DISP_BITS-1];
      if (tree_valid) begin
        out_disp     <= tree_idx;
        out_min_cost <= tree_cost;
      end
    end
  end

endmodule

// File: tb/tb_sgm_disparity_selector.sv
// Self-checking bench for sgm_disparity_selector (D=64 main instance, D=48 padding instance).
module tb_sgm_disparity_selector;

  localparam int D   = 64;
  localparam int D2  = 48;
  localparam int AB  = 8;
  localparam int NP  = 4;
  localparam int DB  = 6;
  localparam int SB  = 10;
  localparam int LAT = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic de = 1'b0, ls = 1'b0;
  logic [NP*D*AB-1:0] L = '0;
  logic ov, ols, obd;
  logic [DB-1:0] odisp;
  logic [SB-1:0] ocost;

  logic de2 = 1'b0, ls2 = 1'b0;
  logic [NP*D2*AB-1:0] L2 = '0;
  logic ov2, ols2, obd2;
  logic [DB-1:0] odisp2;
  logic [SB-1:0] ocost2;

  always #5 clk = ~clk;

  sgm_disparity_selector #(.DISPARITY_LEVELS(D), .ACC_COST_BITS(AB), .NUM_PATHS(NP)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_de(de), .in_line_start(ls), .in_L_arr(L),
    .out_valid(ov), .out_disp(odisp), .out_min_cost(ocost),
    .out_line_start(ols), .out_border(obd));

  sgm_disparity_selector #(.DISPARITY_LEVELS(D2), .ACC_COST_BITS(AB), .NUM_PATHS(NP)) dut48 (
    .in_clk(clk), .in_rst_n(rst_n), .in_de(de2), .in_line_start(ls2), .in_L_arr(L2),
    .out_valid(ov2), .out_disp(odisp2), .out_min_cost(ocost2),
    .out_line_start(ols2), .out_border(obd2));

  typedef struct {int due; int disp; int cost; int border; int lstart;} exp_t;
  exp_t q[$];
  int cyc = 0, mcol = 0;
  int compared = 0, mismatched = 0;
  int n_valid = 0, n_border = 0, n_ls = 0;
  int obs[$];
  int last_disp = 0, last_border = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-vector argmin over summed costs, evaluated per sampled pixel.
  always @(posedge clk) begin
    exp_t e;
    int best, s, c;
    cyc++;
    if (!rst_n) begin
      mcol = 0;
      q.delete();
    end else if (de) begin
      best = -1;
      e.disp = 0;
      for (int d = 0; d < D; d++) begin
        s = 0;
        for (int p = 0; p < NP; p++) s += int'(L[AB*(p*D+d) +: AB]);
        if (best < 0 || s < best) begin best = s; e.disp = d; end
      end
      e.cost = best;
      c = ls ? 0 : mcol;
      mcol = ls ? 1 : ((mcol < D-1) ? mcol + 1 : mcol);
      e.border = (c < D-1) ? 1 : 0;
      e.lstart = ls ? 1 : 0;
      e.due = cyc + LAT;
      q.push_back(e);
    end
  end

  // Compare every cycle; data fields only when a result is due.
  always @(negedge clk) begin
    exp_t e;
    bit ev;
    if (!rst_n) begin
      q.delete();
      chk("valid_in_reset", ov, 0);
    end else begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", ov, ev);
      if (ev) begin
        e = q.pop_front();
        chk("out_disp", odisp, e.disp);
        chk("out_min_cost", ocost, e.cost);
        chk("out_border", obd, e.border);
        chk("out_line_start", ols, e.lstart);
        n_valid++;
        n_border += obd;
        n_ls += ols;
        obs.push_back(int'(odisp));
        last_disp = int'(odisp);
        last_border = int'(obd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input int v);
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < D; d++) L[AB*(p*D+d) +: AB] = AB'(v);
  endtask

  task automatic setc(input int p, input int d, input int v);
    L[AB*(p*D+d) +: AB] = AB'(v);
  endtask

  task automatic send(input bit l);
    de = 1'b1; ls = l;
    step();
    de = 1'b0; ls = 1'b0;
  endtask

  // Wait (bounded) for out_valid on the main instance.
  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (ov) break;
      n++;
    end
    if (n >= 20) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    int exp_a[4];
    exp_a = '{3, 9, 21, 50};

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", ov, 0);
    chk("rst_disp", odisp, 0);
    chk("rst_cost", ocost, 0);
    chk("rst_border", obd, 0);
    chk("rst_line_start", ols, 0);
    chk("rst_valid48", ov2, 0);
    rst_n = 1'b1;
    step();

    // Single pixel: minimum at d=17, exact latency
    fill(10); setc(0, 17, 2);
    de = 1'b1; ls = 1'b1;
    @(posedge clk);
    #2;
    de = 1'b0; ls = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (ov) break;
      @(posedge clk);
      n++;
    end
    chk("t1_latency", n, 7);
    chk("t1_disp", odisp, 17);
    chk("t1_cost", ocost, 32);
    step();

    // All costs 255: lowest disparity wins, no overflow
    fill(255);
    send(1'b0);
    wait_out("t2");
    chk("t2_disp", odisp, 0);
    chk("t2_cost", ocost, 1020);
    step();

    // Tie between d=40 and d=5 (both sum 3)
    fill(200);
    setc(0, 40, 3); setc(1, 40, 0); setc(2, 40, 0); setc(3, 40, 0);
    setc(0, 5, 0);  setc(1, 5, 1);  setc(2, 5, 1);  setc(3, 5, 1);
    send(1'b0);
    wait_out("t3");
    chk("t3_disp", odisp, 5);
    chk("t3_cost", ocost, 3);
    step();

    // Line of 100 pixels back-to-back
    n_valid = 0; n_border = 0; n_ls = 0;
    for (int k = 0; k < 100; k++) begin
      fill(100);
      setc(0, (k * 7) % D, 1);
      de = 1'b1; ls = (k == 0);
      step();
    end
    de = 1'b0; ls = 1'b0;
    repeat (12) step();
    chk("t4_count", n_valid, 100);
    chk("t4_borders", n_border, 63);
    chk("t4_line_starts", n_ls, 1);

    // Alternating in_de with distinct minima
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      fill(100);
      setc(2, exp_a[i], 0);
      send(1'b0);
      step();
    end
    repeat (12) step();
    chk("t5_count", obs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs.size()) chk("t5_order", obs[i], exp_a[i]);
    end

    // Reset mid-flight: three pixels discarded, next pixel sees counter reset
    n_valid = 0;
    for (int i = 0; i < 3; i++) begin
      fill(90);
      setc(1, 10 + i, 0);
      de = 1'b1;
      step();
    end
    de = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    fill(90);
    setc(3, 30, 5);
    send(1'b0);
    repeat (12) step();
    chk("t6_count", n_valid, 1);
    chk("t6_border", last_border, 1);
    chk("t6_disp", last_disp, 30);

    // D=48: padding leaves must never win
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < D2; d++) L2[AB*(p*D2+d) +: AB] = 8'd200;
    L2[AB*(0*D2+47) +: AB] = 8'd1;
    for (int p = 1; p < NP; p++) L2[AB*(p*D2+47) +: AB] = 8'd0;
    de2 = 1'b1;
    @(posedge clk);
    #2;
    de2 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (ov2) break;
      @(posedge clk);
      n++;
    end
    chk("t7_latency", n, 7);
    chk("t7_disp", odisp2, 47);
    chk("t7_cost", ocost2, 1);
    chk("t7_border", obd2, 1);
    chk("t7_line_start", ols2, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
